// File: rtl/adder_share_pkg.sv
// Shared definitions for the time-multiplexed adder scheduler (adder_share_sched).
// Provides id width derivation, response latency and the saturating counter helper.
package adder_share_pkg;

    localparam int RSP_LAT = 2;

    function automatic int id_w(input int cnt);
        return (cnt > 1) ? $clog2(cnt) : 1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// returning both a one-hot grant vector and the granted index.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter  int CNT = 8,
    localparam int IDW = id_w(CNT)
) (
    input  logic [CNT-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic [CNT-1:0] gnt,
    output logic [IDW-1:0] gnt_id
);

    logic [IDW-1:0] idx;

    // Scan from the far end back toward ptr so the last hit written is the nearest one.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = '0;
        for (int k = CNT - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % CNT);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/adder_share_sched.sv
// One N-bit adder shared round-robin among CNT requesters, 2-stage pipeline, tagged responses.
// Optional ADDER_SHARE_STATS_EN adds per-requester saturating grant counters on stat_grants.
module adder_share_sched
    import adder_share_pkg::*;
#(
    parameter  int N   = 12,
    parameter  int CNT = 8,
    localparam int IDW = id_w(CNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT-1:0]   req_valid,
    output logic [CNT-1:0]   req_ready,
    input  logic [CNT*N-1:0] req_a,
    input  logic [CNT*N-1:0] req_b,
    input  logic [CNT-1:0]   req_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [N:0]       rsp_sum
`ifdef ADDER_SHARE_STATS_EN
    ,
    output logic [CNT*16-1:0] stat_grants
`endif
);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic           cin;
    } op_t;

    logic           vld_p0_q, vld_p0_d;
    logic           vld_p1_q, vld_p1_d;
    op_t            op_p0_q, op_p0_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [N:0]     rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic           adv0, adv1, grant;
    logic [CNT-1:0] arb_req, gnt;
    logic [IDW-1:0] gnt_id;

    assign adv1    = !vld_p1_q || rsp_ready;
    assign adv0    = !vld_p0_q || adv1;
    assign arb_req = adv0 ? req_valid : '0;
    assign grant   = |gnt;

    rr_arbiter #(.CNT(CNT)) u_arb (
        .req    (arb_req),
        .ptr    (rr_ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;

    always_comb begin
        vld_p0_d  = vld_p0_q;
        op_p0_d   = op_p0_q;
        vld_p1_d  = vld_p1_q;
        rsp_id_d  = rsp_id_q;
        rsp_sum_d = rsp_sum_q;
        rr_ptr_d  = rr_ptr_q;
        // S0 -> S1: the shared adder sits on this boundary
        if (adv1) begin
            vld_p1_d = vld_p0_q;
            if (vld_p0_q) begin
                rsp_id_d  = op_p0_q.id;
                rsp_sum_d = {1'b0, op_p0_q.a} + {1'b0, op_p0_q.b} + {{N{1'b0}}, op_p0_q.cin};
            end
        end
        // Requests -> S0
        if (adv0) begin
            vld_p0_d = grant;
        end
        if (grant) begin
            op_p0_d.id  = gnt_id;
            op_p0_d.a   = req_a[gnt_id*N +: N];
            op_p0_d.b   = req_b[gnt_id*N +: N];
            op_p0_d.cin = req_cin[gnt_id];
            rr_ptr_d    = (gnt_id == IDW'(CNT - 1)) ? '0 : gnt_id + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            rsp_id_q  <= '0;
            rsp_sum_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            vld_p1_q  <= vld_p1_d;
            rsp_id_q  <= rsp_id_d;
            rsp_sum_q <= rsp_sum_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Operand payload is qualified by vld_p0_q, so it needs no reset.
    always_ff @(posedge clk) begin
        op_p0_q <= op_p0_d;
    end

    assign rsp_valid = vld_p1_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

`ifdef ADDER_SHARE_STATS_EN
    logic [15:0] grants_q [CNT];
    logic [15:0] grants_d [CNT];

    always_comb begin
        for (int i = 0; i < CNT; i++) begin
            grants_d[i] = gnt[i] ? sat_inc16(grants_q[i]) : grants_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CNT; i++) begin
                grants_q[i] <= '0;
            end
        end else begin
            grants_q <= grants_d;
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < CNT; i++) begin
            stat_grants[i*16 +: 16] = grants_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_adder_share_sched.sv
// Scoreboard bench for adder_share_sched: randomized and directed traffic against a queue-based model.
// Build with ADDER_SHARE_STATS_EN defined to also exercise the grant counters.
module tb_adder_share_sched;
    import adder_share_pkg::*;

    localparam int N   = 12;
    localparam int CNT = 8;
    localparam int IDW = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT-1:0]   req_valid = '0;
    logic [CNT-1:0]   req_ready;
    logic [CNT*N-1:0] req_a = '0;
    logic [CNT*N-1:0] req_b = '0;
    logic [CNT-1:0]   req_cin = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IDW-1:0]   rsp_id;
    logic [N:0]       rsp_sum;
`ifdef ADDER_SHARE_STATS_EN
    logic [CNT*16-1:0] stat_grants;
`endif

    adder_share_sched #(.N(N), .CNT(CNT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
`ifdef ADDER_SHARE_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected response: who, what, and the edge at which it was accepted.
    typedef struct {
        int id;
        int sum;
        int acc;
    } item_t;

    item_t sb[$];
    int    last_drain = 0;
    int    rr_m = 0;
    int    grants_m [CNT];
    int    a_m [CNT];
    int    b_m [CNT];
    int    c_m [CNT];
    int    n_tests = 0;
    int    n_fail = 0;
    bit    done = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // An op becomes visible RSP_LAT-1 edges after acceptance, but never before its predecessor drained.
    function automatic bit head_visible();
        int vis;
        if (sb.size() == 0) return 1'b0;
        vis = sb[0].acc + RSP_LAT - 1;
        if (last_drain > vis) vis = last_drain;
        return cyc >= vis;
    endfunction

    task automatic drive(input logic [CNT-1:0] rv, input bit rdy,
                         input int fid, input int fa, input int fb, input int fc);
        int  rvi;
        int  exp_gnt;
        int  exp_ready;
        bit  can;
        @(posedge clk);
        #1;
        for (int i = 0; i < CNT; i++) begin
            a_m[i] = int'($urandom_range(0, 4095));
            b_m[i] = int'($urandom_range(0, 4095));
            c_m[i] = int'($urandom_range(0, 1));
        end
        if (fid >= 0) begin
            a_m[fid] = fa;
            b_m[fid] = fb;
            c_m[fid] = fc;
        end
        for (int i = 0; i < CNT; i++) begin
            req_a[i*N +: N] = N'(a_m[i]);
            req_b[i*N +: N] = N'(b_m[i]);
            req_cin[i]      = (c_m[i] != 0);
        end
        req_valid = rv;
        rsp_ready = rdy;
        #1;
        rvi = int'(rv);
        can = (sb.size() < 2) || (head_visible() && rdy);
        exp_gnt = -1;
        if (can) begin
            for (int k = 0; k < CNT; k++) begin
                int j;
                j = (rr_m + k) % CNT;
                if (exp_gnt < 0 && ((rvi >> j) & 1) == 1) exp_gnt = j;
            end
        end
        exp_ready = (exp_gnt >= 0) ? (1 << exp_gnt) : 0;
        check("req_ready", int'(req_ready), exp_ready);
        if (exp_gnt >= 0) begin
            sb.push_back('{exp_gnt, a_m[exp_gnt] + b_m[exp_gnt] + c_m[exp_gnt], cyc + 1});
            rr_m = (exp_gnt + 1) % CNT;
            grants_m[exp_gnt]++;
        end
    endtask

    task automatic step(input logic [CNT-1:0] rv, input bit rdy);
        drive(rv, rdy, -1, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        sb.delete();
        rr_m       = 0;
        last_drain = 0;
        for (int i = 0; i < CNT; i++) grants_m[i] = 0;
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_id", int'(rsp_id), 0);
        check("reset_rsp_sum", int'(rsp_sum), 0);
        check("reset_req_ready", int'(req_ready), 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) step('0, 1'b1);
        check("drain_empty", sb.size(), 0);
    endtask

`ifdef ADDER_SHARE_STATS_EN
    task automatic check_stats();
        for (int i = 0; i < CNT; i++) begin
            int e;
            e = (grants_m[i] > 65535) ? 65535 : grants_m[i];
            check($sformatf("stat_grants[%0d]", i), int'(stat_grants[i*16 +: 16]), e);
        end
    endtask
`endif

    // Monitor: compares the response bus against the scoreboard head every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (done) break;
            if (rst_n) begin
                bit ev;
                ev = head_visible();
                check("rsp_valid", int'(rsp_valid), int'(ev));
                if (ev && rsp_valid) begin
                    check("rsp_id", int'(rsp_id), sb[0].id);
                    check("rsp_sum", int'(rsp_sum), sb[0].sum);
                end
                if (ev && rsp_ready) begin
                    void'(sb.pop_front());
                    last_drain = cyc + 1;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < CNT; i++) grants_m[i] = 0;
        do_reset();

        drive(8'h08, 1'b1, 3, 12'hFFF, 12'h001, 1);
        drain();

        do_reset();
        for (int i = 0; i < 9; i++) step(8'hFF, 1'b1);
        drain();

        for (int i = 0; i < 5; i++) step(8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) step(8'hFF, 1'b1);
        drain();

        step(8'h80, 1'b1);
        step(8'h41, 1'b1);
        step(8'h40, 1'b1);
        drain();

        for (int i = 0; i < 400; i++) begin
            logic [CNT-1:0] rv;
            rv = (i % 3 == 0) ? CNT'($urandom) : CNT'($urandom & $urandom);
            step(rv, $urandom_range(0, 3) != 0);
        end
        drain();
`ifdef ADDER_SHARE_STATS_EN
        check_stats();
`endif

        for (int i = 0; i < 3; i++) step(8'hFF, 1'b0);
        do_reset();
        step(8'h20, 1'b1);
        step(8'hFF, 1'b1);
        drain();

`ifdef ADDER_SHARE_STATS_EN
        do_reset();
        for (int i = 0; i < 70000; i++) step(8'h04, 1'b1);
        drain();
        check_stats();
`endif

        done = 1'b1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
